mem_rmw_ctrl: RTL and testbench

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

---
 rtl/mem_rmw_ctrl_pkg.sv | 50 +++++
 rtl/mem_rmw_ctrl_load_ext.sv | 44 ++++
 rtl/mem_rmw_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_rmw_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rmw_ctrl_pkg.sv
// mem_rmw_ctrl_pkg
//   Shared definitions for the MEM-stage read-modify-write controller and the
//   load extension unit (also used by the writeback stage):
//   - mem_op_e    : req_op encoding (loads first, then stores)
//   - rmw_state_e : controller FSM state encoding
//   - helper functions classifying an operation and checking alignment
package mem_rmw_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } rmw_state_e;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DM_AW  = 10;

    function automatic logic op_is_load(input mem_op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    // Byte and half stores need the old word, hence the extra MERGE cycle.
    function automatic logic op_is_subword_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    // Words need offset 0, halves need an even offset, bytes never fault.
    function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LW, OP_SW:          mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH:  mis = off[0];
            default:               mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_rmw_ctrl_load_ext.sv
// load_ext
//   Selects the addressed byte/half of a little-endian word and sign- or
//   zero-extends it according to the load opcode. LW passes the word through.
//   Ports:
//     op_i       [2:0]  load opcode (mem_op_e encoding)
//     byte_off_i [1:0]  byte offset within the word (address bits 1:0)
//     word_i     [31:0] word read from data memory
//     data_o     [31:0] extended load result
module load_ext
    import mem_rmw_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (byte_off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Only even offsets reach here for halves; bit 1 picks the half.
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (mem_op_e'(op_i))
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'h0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl
//   MEM-stage data memory controller. Loads and SW complete in the request
//   cycle. SB/SH are done as read-modify-write: the IDLE cycle reads the old
//   word, merges the new lane and stalls; the MERGE cycle writes the merged
//   word back. All outputs are combinational from state and request.
//   Handshake: a request is presented with req_valid; while stall is high the
//   request stays stable, and it is consumed on the first edge with stall low.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req_valid/op/addr/wdata/pc   MEM-stage memory instruction
//     stall               hold the pipeline (first cycle of SB/SH)
//     ld_valid, ld_data   load result (ld_data is 0 unless ld_valid)
//     addr_err            misaligned access
//     dm_MemWrite/Addr/WD/PC       data memory write port and trace PC
//     dm_RD               combinational read word from data memory
module mem_rmw_ctrl
    import mem_rmw_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        addr_err,
    output logic        dm_MemWrite,
    output logic [9:0]  dm_Addr,
    output logic [31:0] dm_WD,
    output logic [31:0] dm_PC,
    input  logic [31:0] dm_RD
);

    rmw_state_e  state_q;
    logic [9:0]  addr_q;
    logic [31:0] pc_q;
    logic [31:0] wd_q;

    mem_op_e     op;
    logic [1:0]  off;
    logic        active;
    logic        mis;
    logic        do_load;
    logic        do_sw;
    logic        start_rmw;
    logic        in_merge;
    logic [31:0] merge_d;
    logic [31:0] ext_data;

    // Word index only uses address bits 11:2; the rest is ignored.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:12];

    assign op  = mem_op_e'(req_op);
    assign off = req_addr[1:0];

    // A request is only acted on in IDLE and never during a reset cycle.
    assign active    = req_valid && (state_q == ST_IDLE) && !reset;
    assign mis       = op_misaligned(op, off);
    assign do_load   = active && !mis && op_is_load(op);
    assign do_sw     = active && !mis && (op == OP_SW);
    assign start_rmw = active && !mis && op_is_subword_store(op);
    // Reset in MERGE drops the pending write.
    assign in_merge  = (state_q == ST_MERGE) && !reset;

    load_ext u_load_ext (
        .op_i       (req_op),
        .byte_off_i (off),
        .word_i     (dm_RD),
        .data_o     (ext_data)
    );

    // Old word with the addressed lane replaced by the store data.
    always_comb begin
        merge_d = dm_RD;
        if (op == OP_SB) begin
            case (off)
                2'd0:    merge_d[7:0]   = req_wdata[7:0];
                2'd1:    merge_d[15:8]  = req_wdata[7:0];
                2'd2:    merge_d[23:16] = req_wdata[7:0];
                default: merge_d[31:24] = req_wdata[7:0];
            endcase
        end else if (off[1]) begin
            merge_d[31:16] = req_wdata[15:0];
        end else begin
            merge_d[15:0] = req_wdata[15:0];
        end
    end

    assign addr_err    = active && mis;
    assign ld_valid    = do_load;
    assign ld_data     = do_load ? ext_data : 32'h0;
    assign stall       = start_rmw;
    assign dm_MemWrite = in_merge || do_sw;
    assign dm_WD       = in_merge ? wd_q : (do_sw ? req_wdata : 32'h0);
    assign dm_Addr     = (state_q == ST_MERGE) ? addr_q : req_addr[11:2];
    assign dm_PC       = (state_q == ST_MERGE) ? pc_q : req_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            pc_q    <= '0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rmw) begin
                        state_q <= ST_MERGE;
                        addr_q  <= req_addr[11:2];
                        pc_q    <= req_pc;
                        wd_q    <= merge_d;
                    end
                end
                ST_MERGE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
module tb_mem_rmw_ctrl;
  import mem_rmw_ctrl_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        addr_err;
  logic        dm_MemWrite;
  logic [9:0]  dm_Addr;
  logic [31:0] dm_WD;
  logic [31:0] dm_PC;
  logic [31:0] dm_RD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_rmw_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_pc      (req_pc),
    .stall       (stall),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .addr_err    (addr_err),
    .dm_MemWrite (dm_MemWrite),
    .dm_Addr     (dm_Addr),
    .dm_WD       (dm_WD),
    .dm_PC       (dm_PC),
    .dm_RD       (dm_RD)
  );

  // ---------------- data memory + write monitor ----------------
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [73:0] exp_q[$];
  logic [73:0] obs_q[$];

  assign dm_RD = mem[dm_Addr];

  always @(posedge clk) begin
    if (dm_MemWrite === 1'b1) begin
      obs_q.push_back({dm_Addr, dm_WD, dm_PC});
      mem[dm_Addr] <= dm_WD;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] p);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = w;
    req_pc    = p;
  endtask

  task automatic check_outs(input string tag, input logic e_stall, input logic e_ldv,
                            input logic [31:0] e_ld, input logic e_err, input logic e_we,
                            input logic [9:0] e_addr, input logic [31:0] e_wd,
                            input logic [31:0] e_pc);
    @(negedge clk);
    check({tag, ".stall"},    {31'b0, stall},       {31'b0, e_stall});
    check({tag, ".ld_valid"}, {31'b0, ld_valid},    {31'b0, e_ldv});
    check({tag, ".ld_data"},  ld_data,              e_ld);
    check({tag, ".addr_err"}, {31'b0, addr_err},    {31'b0, e_err});
    check({tag, ".we"},       {31'b0, dm_MemWrite}, {31'b0, e_we});
    check({tag, ".dm_Addr"},  {22'b0, dm_Addr},     {22'b0, e_addr});
    check({tag, ".dm_WD"},    dm_WD,                e_wd);
    check({tag, ".dm_PC"},    dm_PC,                e_pc);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    req_valid = 1'b0;
    pre_we    = 1'b1;
    pre_addr  = idx;
    pre_data  = data;
    ref_mem[idx] = data;
    tick();
    pre_we = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] off);
    if (op == OP_LW || op == OP_SW) return off == 2'b00;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return off[0] == 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] word,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    if (op == OP_LB)  return {{24{sh[7]}}, sh[7:0]};
    if (op == OP_LBU) return {24'h0, sh[7:0]};
    if (op == OP_LH)  return {{16{sh[15]}}, sh[15:0]};
    if (op == OP_LHU) return {16'h0, sh[15:0]};
    return word;
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] op, input logic [31:0] word,
                                              input logic [31:0] w, input logic [1:0] off);
    logic [31:0] mask;
    mask = ((op == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF) << {off, 3'b000};
    return (word & ~mask) | ((w << {off, 3'b000}) & mask);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic        e_ldv;
    logic [31:0] e_ld;
    logic        e_err;
    logic        e_we;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] p;
    logic [31:0] hi;
    logic [31:0] word;
    logic [31:0] e_ld;
    logic [3:0]  widx;
    logic [1:0]  off;
    logic [2:0]  op;
    logic        v;
    logic [73:0] e_ent;
    logic [73:0] o_ent;
    int          n_wr;

    n_cmp  = 0;
    n_fail = 0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;

    vecs[0]  = '{OP_SW,  32'h10,       32'h12345678, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678};
    vecs[1]  = '{OP_LB,  32'h13,       32'h0,        32'h82345678, 1'b1, 32'hFFFFFF82, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{OP_LBU, 32'h13,       32'h0,        32'h82345678, 1'b1, 32'h00000082, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{OP_LH,  32'h12,       32'h0,        32'h82345678, 1'b1, 32'hFFFF8234, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{OP_LHU, 32'h12,       32'h0,        32'h82345678, 1'b1, 32'h00008234, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{OP_LW,  32'h10,       32'h0,        32'h82345678, 1'b1, 32'h82345678, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{OP_LW,  32'h12,       32'h0,        32'h82345678, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[7]  = '{OP_SH,  32'h13,       32'hBEEF,     32'h82345678, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[8]  = '{OP_LB,  32'h10,       32'h0,        32'h82345678, 1'b1, 32'h00000078, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{OP_LH,  32'h10,       32'h0,        32'h82345678, 1'b1, 32'h00005678, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{OP_SW,  32'h11,       32'hCAFEF00D, 32'h82345678, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[11] = '{OP_LBU, 32'hFFFFF011, 32'h0,        32'h82345678, 1'b1, 32'h00000056, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{OP_LB,  32'h11,       32'h0,        32'h0000F000, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{OP_LHU, 32'h11,       32'h0,        32'h0000F000, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};

    // ---- reset cycles: outputs gated whatever the request ----
    reset = 1'b1;
    set_req(1'b1, OP_SW, 32'h10, 32'h12345678, 32'h40);
    tick();
    check_outs("rst_sw", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd4, 32'h0, 32'h40);
    tick();
    set_req(1'b1, OP_LW, 32'h12, 32'h0, 32'h44);
    check_outs("rst_mis", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd4, 32'h0, 32'h44);
    tick();
    set_req(1'b1, OP_SB, 32'h11, 32'hAB, 32'h48);
    check_outs("rst_sb", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd4, 32'h0, 32'h48);
    tick();
    reset = 1'b0;
    set_req(1'b0, OP_SW, 32'h0000_0ABC, 32'hFFFF_FFFF, 32'h4C);
    check_outs("idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h2AF, 32'h0, 32'h4C);
    tick();

    // ---- table-driven single-cycle operations ----
    for (int i = 0; i < 14; i++) begin
      preload(10'd4, vecs[i].init);
      a = vecs[i].addr;
      p = 32'h1000 + 32'(i) * 4;
      set_req(1'b1, vecs[i].op, a, vecs[i].wdata, p);
      check_outs($sformatf("vec%0d", i), 1'b0, vecs[i].e_ldv, vecs[i].e_ld, vecs[i].e_err,
                 vecs[i].e_we, a[11:2], vecs[i].e_wd, p);
      if (vecs[i].e_we) begin
        exp_q.push_back({a[11:2], vecs[i].e_wd, p});
        ref_mem[a[11:2]] = vecs[i].e_wd;
      end
      tick();
    end

    // ---- SB read-modify-write; inputs changed during MERGE are ignored ----
    preload(10'd4, 32'h12345678);
    set_req(1'b1, OP_SB, 32'h11, 32'hAB, 32'h100);
    check_outs("sb_c1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd4, 32'h0, 32'h100);
    tick();
    set_req(1'b1, OP_LW, 32'h3FC, 32'h5555_5555, 32'h999);
    check_outs("sb_c2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 10'd4, 32'h1234AB78, 32'h100);
    exp_q.push_back({10'd4, 32'h1234AB78, 32'h100});
    tick();
    set_req(1'b1, OP_LW, 32'h10, 32'h0, 32'h104);
    check_outs("sb_rd", 1'b0, 1'b1, 32'h1234AB78, 1'b0, 1'b0, 10'd4, 32'h0, 32'h104);
    tick();

    // ---- SH aborted by reset in MERGE ----
    preload(10'd4, 32'h12345678);
    set_req(1'b1, OP_SH, 32'h12, 32'hBEEF, 32'h200);
    check_outs("sh_c1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd4, 32'h0, 32'h200);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("sh_rst.we", {31'b0, dm_MemWrite}, 32'h0);
    check("sh_rst.stall", {31'b0, stall}, 32'h0);
    check("sh_rst.ld_valid", {31'b0, ld_valid}, 32'h0);
    tick();
    reset = 1'b0;
    set_req(1'b0, OP_LW, 32'h40, 32'h0, 32'h300);
    check_outs("sh_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd16, 32'h0, 32'h300);
    tick();
    set_req(1'b1, OP_LW, 32'h10, 32'h0, 32'h304);
    check_outs("sh_keep", 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 10'd4, 32'h0, 32'h304);
    tick();

    // ---- SB then dependent LW ----
    preload(10'd4, 32'h0);
    set_req(1'b1, OP_SB, 32'h10, 32'hCD, 32'h400);
    check_outs("sb2_c1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd4, 32'h0, 32'h400);
    tick();
    check_outs("sb2_c2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 10'd4, 32'h000000CD, 32'h400);
    exp_q.push_back({10'd4, 32'h000000CD, 32'h400});
    tick();
    set_req(1'b1, OP_LW, 32'h10, 32'h0, 32'h404);
    check_outs("sb2_lw", 1'b0, 1'b1, 32'h000000CD, 1'b0, 1'b0, 10'd4, 32'h0, 32'h404);
    tick();

    // ---- randomized traffic against the reference model ----
    for (int k = 0; k < 16; k++) preload(10'(k), $urandom());
    for (int it = 0; it < 300; it++) begin
      v    = ($urandom_range(0, 7) != 0);
      op   = 3'($urandom_range(0, 7));
      widx = 4'($urandom_range(0, 15));
      off  = 2'($urandom_range(0, 3));
      hi   = $urandom();
      a    = {hi[19:0], 6'b0, widx, off};
      w    = $urandom();
      p    = $urandom();
      word = ref_mem[{6'b0, widx}];
      set_req(v, op, a, w, p);
      if (!v) begin
        check_outs("rnd_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, a[11:2], 32'h0, p);
      end else if (!is_aligned(op, off)) begin
        check_outs("rnd_mis", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, a[11:2], 32'h0, p);
      end else if (op == OP_SW) begin
        check_outs("rnd_sw", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a[11:2], w, p);
        exp_q.push_back({a[11:2], w, p});
        ref_mem[{6'b0, widx}] = w;
      end else if (op == OP_SB || op == OP_SH) begin
        check_outs("rnd_sub1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, a[11:2], 32'h0, p);
        tick();
        hi = $urandom();
        set_req(hi[0], 3'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom());
        word = model_merge(op, word, w, off);
        check_outs("rnd_sub2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, {6'b0, widx}, word, p);
        exp_q.push_back({6'b0, widx, word, p});
        ref_mem[{6'b0, widx}] = word;
      end else begin
        e_ld = model_load(op, word, off);
        check_outs("rnd_ld", 1'b0, 1'b1, e_ld, 1'b0, 1'b0, a[11:2], 32'h0, p);
      end
      tick();
    end

    // ---- final memory image and write trace ----
    req_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++)
      check($sformatf("mem[%0d]", k), mem[k], ref_mem[k]);
    check("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n_wr = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n_wr; k++) begin
      e_ent = exp_q[k];
      o_ent = obs_q[k];
      check($sformatf("wr%0d.addr", k), {22'b0, o_ent[73:64]}, {22'b0, e_ent[73:64]});
      check($sformatf("wr%0d.data", k), o_ent[63:32], e_ent[63:32]);
      check($sformatf("wr%0d.pc", k), o_ent[31:0], e_ent[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
